// File: rtl/cl_dram_dma_scratch_pkg.sv
// Shared types and constants for the DMA scratch-memory AXI slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cl_dram_dma_scratch_pkg;

    // One AXI data beat is always one full scratch line.
    localparam int LINE_BYTES = 64;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int LINE_OFS_W = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_RESP  = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } scratch_state_e;

endpackage

// File: rtl/cl_dram_dma_axi_scratch_slv_if.sv
// AXI4 bus bundle (512-bit data, 64-bit address) between a requester and the scratch slave.
// Latency: n/a (wiring only).
// Backpressure: plain AXI valid/ready on every channel.
interface axi_bus_t #(
    parameter int ID_W = 16
) ();
    import cl_dram_dma_scratch_pkg::*;

    logic [ID_W-1:0]       awid;
    logic [63:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;

    logic [LINE_BITS-1:0]  wdata;
    logic [LINE_BYTES-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_W-1:0]       arid;
    logic [63:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;

    logic [ID_W-1:0]       rid;
    logic [LINE_BITS-1:0]  rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    // Existing codebase orientation: the "master" modport is worn by the
    // responder (it drives B/R); "slave" is worn by the requester.
    modport master (
        input  awid, awaddr, awlen, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid,          output wready,
        output bid, bresp, bvalid,                   input  bready,
        input  arid, araddr, arlen, arsize, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid,     input  rready
    );

    modport slave (
        output awid, awaddr, awlen, awsize, awvalid, input  awready,
        output wdata, wstrb, wlast, wvalid,          input  wready,
        input  bid, bresp, bvalid,                   output bready,
        output arid, araddr, arlen, arsize, arvalid, input  arready,
        input  rid, rdata, rresp, rlast, rvalid,     output rready
    );

endinterface

// File: rtl/cl_dram_dma_scratch_ram.sv
// Single-port line memory with per-byte write enables.
// Latency: writes land on the clock edge; reads return one cycle after rd_en_i.
// Backpressure: none; read data holds until the next rd_en_i.
module cl_dram_dma_scratch_ram
    import cl_dram_dma_scratch_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                  clk_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [LINE_BYTES-1:0] wr_be_i,
    input  logic [LINE_BITS-1:0]  wdata_i,
    input  logic                  rd_en_i,
    output logic [LINE_BITS-1:0]  rdata_o
);

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];
    logic [LINE_BITS-1:0] rdata_q;

    // Byte-masked write and registered read share the single address port.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (wr_be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cl_dram_dma_axi_scratch_slv.sv
// AXI4 slave fronting a DEPTH_LINES x 512-bit scratch memory, one transaction at a time.
// Latency: write beat per cycle then B next cycle; reads take 2 cycles per beat (fetch + data).
// Backpressure: stalls on wvalid/bready/rready; AW/AR only accepted in IDLE, AW wins ties.
// Optional build macro SCRATCH_RANGE_CHK_EN: bursts running past the last line get SLVERR,
// writes dropped and read data zeroed; otherwise high address bits are ignored and indices wrap.
module cl_dram_dma_axi_scratch_slv
    import cl_dram_dma_scratch_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int ID_W        = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi_bus_t.master    slv_bus,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt
);

    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int IDX_LO = LINE_OFS_W;
    localparam int IDX_HI = LINE_OFS_W + IDX_W - 1;

    scratch_state_e        state_q;
    logic [ID_W-1:0]       id_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic                  awready_q;
    logic                  arready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [31:0]           wr_cnt_q;
    logic [31:0]           rd_cnt_q;

    logic                  aw_err_d;
    logic                  ar_err_d;
    logic [LINE_BYTES-1:0] ram_be;
    logic                  ram_rd;
    logic [LINE_BITS-1:0]  ram_rdata;

`ifdef SCRATCH_RANGE_CHK_EN
    // A burst is out of range if it starts above the array or its last line
    // (start + len) would carry past the top index.
    function automatic logic burst_oob(input logic [63:0] addr, input logic [7:0] len);
        logic [IDX_W+8:0] last_line;
        last_line = {9'd0, addr[IDX_HI:IDX_LO]} + {{(IDX_W+1){1'b0}}, len};
        return (|addr[63:IDX_HI+1]) | (|last_line[IDX_W+8:IDX_W]);
    endfunction

    assign aw_err_d = burst_oob(slv_bus.awaddr, slv_bus.awlen);
    assign ar_err_d = burst_oob(slv_bus.araddr, slv_bus.arlen);

    logic unused_bus;
    assign unused_bus = ^{slv_bus.awsize, slv_bus.arsize, slv_bus.wlast,
                          slv_bus.awaddr[IDX_LO-1:0], slv_bus.araddr[IDX_LO-1:0]};
`else
    assign aw_err_d = 1'b0;
    assign ar_err_d = 1'b0;

    // Size and wlast never steer the FSM; high address bits simply alias.
    logic unused_bus;
    assign unused_bus = ^{slv_bus.awsize, slv_bus.arsize, slv_bus.wlast,
                          slv_bus.awaddr[IDX_LO-1:0], slv_bus.araddr[IDX_LO-1:0],
                          slv_bus.awaddr[63:IDX_HI+1], slv_bus.araddr[63:IDX_HI+1]};
`endif

    // Transaction FSM; every handshake output is a register updated here.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b1;
            arready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (slv_bus.awvalid) begin
                        id_q      <= slv_bus.awid;
                        len_q     <= slv_bus.awlen;
                        idx_q     <= slv_bus.awaddr[IDX_HI:IDX_LO];
                        err_q     <= aw_err_d;
                        beat_q    <= '0;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= WR_DATA;
                    end else if (slv_bus.arvalid) begin
                        id_q      <= slv_bus.arid;
                        len_q     <= slv_bus.arlen;
                        idx_q     <= slv_bus.araddr[IDX_HI:IDX_LO];
                        err_q     <= ar_err_d;
                        beat_q    <= '0;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        state_q   <= RD_FETCH;
                    end
                end
                WR_DATA: begin
                    // Burst length comes from awlen alone; an early wlast is ignored.
                    if (slv_bus.wvalid) begin
                        idx_q  <= idx_q + 1'b1;
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == len_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (slv_bus.bready) begin
                        bvalid_q  <= 1'b0;
                        wr_cnt_q  <= wr_cnt_q + 32'd1;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RD_FETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (beat_q == len_q);
                    state_q  <= RD_DATA;
                end
                RD_DATA: begin
                    if (slv_bus.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            rd_cnt_q  <= rd_cnt_q + 32'd1;
                            awready_q <= 1'b1;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            beat_q  <= beat_q + 8'd1;
                            state_q <= RD_FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gate writes with reset so a beat presented in the reset cycle is abandoned too.
    assign ram_be = (state_q == WR_DATA && slv_bus.wvalid && !err_q && aresetn)
                    ? slv_bus.wstrb : '0;
    assign ram_rd = (state_q == RD_FETCH);

    cl_dram_dma_scratch_ram #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i   (aclk),
        .addr_i  (idx_q),
        .wr_be_i (ram_be),
        .wdata_i (slv_bus.wdata),
        .rd_en_i (ram_rd),
        .rdata_o (ram_rdata)
    );

    assign slv_bus.awready = awready_q;
    assign slv_bus.arready = arready_q & ~slv_bus.awvalid;
    assign slv_bus.wready  = wready_q;
    assign slv_bus.bvalid  = bvalid_q;
    assign slv_bus.bid     = id_q;
    assign slv_bus.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign slv_bus.rvalid  = rvalid_q;
    assign slv_bus.rid     = id_q;
    assign slv_bus.rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign slv_bus.rlast   = rlast_q;
    assign slv_bus.rdata   = err_q ? '0 : ram_rdata;

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_cl_dram_dma_axi_scratch_slv.sv
// Directed bench for the scratch AXI slave with a reference memory and B/R scoreboards.
// Latency: n/a.
// Backpressure: exercises rready stalls and held B responses.
module tb_cl_dram_dma_axi_scratch_slv;
    import cl_dram_dma_scratch_pkg::*;

`ifdef SCRATCH_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    always #5 aclk = ~aclk;

    axi_bus_t #(.ID_W(16)) bus ();

    cl_dram_dma_axi_scratch_slv #(
        .DEPTH_LINES (64),
        .ID_W        (16)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .slv_bus (bus),
        .wr_cnt  (wr_cnt),
        .rd_cnt  (rd_cnt)
    );

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  resp;
    } bexp_t;

    typedef struct packed {
        logic [15:0]  id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
    } rexp_t;

    bexp_t        bq[$];
    rexp_t        rq[$];
    logic [511:0] ref_mem [0:63];
    logic [511:0] wbuf    [0:63];
    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_wr = 0;
    int           exp_rd = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed no handshake expected one within 50 cycles", tag);
    endtask

    function automatic logic oob(input logic [63:0] a, input logic [7:0] len);
        return RANGE_CHK && ((a[63:12] != 52'd0) || ((int'(a[11:6]) + int'(len)) >= 64));
    endfunction

    // Write burst from wbuf; abort_at >= 0 pulls reset while that beat would be offered.
    task automatic do_write(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [63:0] strb, input int wlast_at, input int abort_at);
        logic  err;
        int    idx;
        int    n;
        bexp_t be;
        err = oob(addr, len);
        idx = int'(addr[11:6]);
        for (int b = 0; b <= int'(len); b++) begin
            if (abort_at >= 0 && b >= abort_at) break;
            if (!err) begin
                for (int y = 0; y < 64; y++)
                    if (strb[y]) ref_mem[(idx + b) % 64][y*8 +: 8] = wbuf[b][y*8 +: 8];
            end
        end
        if (abort_at < 0) bq.push_back('{id: id, resp: err ? RESP_SLVERR : RESP_OKAY});

        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd6;
        for (n = 0; n < 50; n++) begin #1; if (bus.awready) break; @(negedge aclk); end
        if (n == 50) tmo("aw_hs");
        @(negedge aclk);
        bus.awvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                aresetn = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
                @(negedge aclk); #1;
                chk("rst_bvalid", bus.bvalid, 0);
                chk("rst_wready", bus.wready, 0);
                chk("rst_awready", bus.awready, 1);
                chk("rst_wr_cnt", wr_cnt, 0);
                aresetn = 1'b1; exp_wr = 0; exp_rd = 0;
                @(negedge aclk);
                return;
            end
            bus.wvalid = 1'b1; bus.wdata = wbuf[b]; bus.wstrb = strb; bus.wlast = (b == wlast_at);
            for (n = 0; n < 50; n++) begin #1; if (bus.wready) break; @(negedge aclk); end
            if (n == 50) tmo("w_hs");
            @(negedge aclk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        bus.bready = 1'b1;
        for (n = 0; n < 50; n++) begin #1; if (bus.bvalid) break; @(negedge aclk); end
        if (n == 50) tmo("b_hs");
        else begin
            be = bq.pop_front();
            chk("bid", bus.bid, be.id);
            chk("bresp", bus.bresp, be.resp);
            exp_wr++;
        end
        @(negedge aclk);
        bus.bready = 1'b0;
        #1;
        chk("wr_cnt", wr_cnt, 32'(exp_wr));
        chk("b_single", bus.bvalid, 0);
        @(negedge aclk);
    endtask

    // Read burst; beat stall_beat is held with rready low for stall_cyc cycles.
    task automatic do_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input int stall_beat, input int stall_cyc);
        logic  err;
        int    idx;
        int    n;
        rexp_t e;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd6;
        for (n = 0; n < 50; n++) begin #1; if (bus.arready) break; @(negedge aclk); end
        if (n == 50) begin tmo("ar_hs"); bus.arvalid = 1'b0; return; end
        err = oob(addr, len);
        idx = int'(addr[11:6]);
        for (int b = 0; b <= int'(len); b++)
            rq.push_back('{id: id, data: err ? '0 : ref_mem[(idx + b) % 64],
                           resp: err ? RESP_SLVERR : RESP_OKAY, last: (b == int'(len))});
        @(negedge aclk);
        bus.arvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            bus.rready = (b != stall_beat);
            for (n = 0; n < 50; n++) begin #1; if (bus.rvalid) break; @(negedge aclk); end
            if (n == 50) begin tmo("r_hs"); bus.rready = 1'b0; return; end
            if (b == stall_beat) begin
                for (int k = 0; k < stall_cyc; k++) begin
                    e = rq[0];
                    chk("stall_rvalid", bus.rvalid, 1);
                    chk("stall_rdata", bus.rdata, e.data);
                    chk("stall_rid", bus.rid, e.id);
                    chk("stall_rlast", bus.rlast, e.last);
                    @(negedge aclk); #1;
                end
                bus.rready = 1'b1;
            end
            e = rq.pop_front();
            chk("rdata", bus.rdata, e.data);
            chk("rid", bus.rid, e.id);
            chk("rresp", bus.rresp, e.resp);
            chk("rlast", bus.rlast, e.last);
            @(negedge aclk);
        end
        bus.rready = 1'b0;
        exp_rd++;
        #1;
        chk("rd_cnt", rd_cnt, 32'(exp_rd));
        chk("r_idle", bus.rvalid, 0);
        @(negedge aclk);
    endtask

    task automatic fill_wbuf(input int beats);
        for (int b = 0; b < beats; b++)
            for (int w = 0; w < 16; w++) wbuf[b][w*32 +: 32] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        aresetn = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_awready", bus.awready, 1);
        chk("rst_arready", bus.arready, 1);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Give every line a known value, then sample some back
        fill_wbuf(64);
        do_write(16'h0001, 64'h0, 8'd63, 64'hFFFF_FFFF_FFFF_FFFF, 63, -1);
        do_read(16'h0101, 64'h0, 8'd7, -1, 0);

        // Single partial-strobe write to line 1
        fill_wbuf(1);
        wbuf[0][31:0] = 32'hDEAD_BEEF;
        do_write(16'h0025, 64'h40, 8'd0, 64'h0000_0000_0000_000F, 0, -1);
        chk("line1_word0", ref_mem[1][31:0], 32'hDEAD_BEEF);
        do_read(16'h0125, 64'h40, 8'd0, -1, 0);

        // Burst starting at the top line: wraps, or SLVERR with the range check
        fill_wbuf(4);
        do_write(16'h0026, 64'hFC0, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3, -1);
        do_read(16'h0126, 64'hFC0, 8'd3, -1, 0);
        do_read(16'h0226, 64'h0, 8'd3, -1, 0);

        // Address bits above the index
        fill_wbuf(1);
        do_write(16'h0031, 64'h1_0000_00C0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
        do_read(16'h0131, 64'hC0, 8'd0, -1, 0);

        // AW and AR presented together: write first, read sees new data
        fill_wbuf(1);
        fork
            do_write(16'h0027, 64'h80, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
            do_read(16'h0127, 64'h80, 8'd0, -1, 0);
            begin
                #1;
                chk("tie_awready", bus.awready, 1);
                chk("tie_arready", bus.arready, 0);
            end
        join

        // Read burst with a 5-cycle rready stall on beat 1
        do_read(16'h0028, 64'h100, 8'd2, 1, 5);

        // Early wlast is ignored
        fill_wbuf(2);
        do_write(16'h0030, 64'h200, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
        do_read(16'h0130, 64'h200, 8'd1, -1, 0);

        // Reset in the middle of a 4-beat write
        fill_wbuf(4);
        do_write(16'h0029, 64'h300, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 2);
        #1;
        chk("post_rst_rd_cnt", rd_cnt, 0);
        chk("post_rst_arready", bus.arready, 1);
        @(negedge aclk);
        fill_wbuf(1);
        do_write(16'h002A, 64'h400, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
        do_read(16'h0129, 64'h300, 8'd3, -1, 0);

        chk("bq_empty", 512'(bq.size()), 0);
        chk("rq_empty", 512'(rq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cl_dram_dma_axi_scratch_slv.md
CL_DRAM_DMA_AXI_SCRATCH_SLV -- requirements
Module: cl_dram_dma_axi_scratch_slv

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 64, number of 512-bit lines in the scratch memory (power of two, 2..1024).
REQ-002 SHALL have parameter ID_W, default 16, AXI ID width used for awid/arid/bid/rid.
REQ-003 SHALL have port aclk, input, 1, clock.
REQ-004 SHALL have port aresetn, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port slv_bus, axi_bus_t.master modport, 512-bit data, 64-bit address, AXI4 slave side (receives AW/W/AR, drives B/R).
REQ-006 SHALL have port wr_cnt, output, 32, count of completed write transactions.
REQ-007 SHALL have port rd_cnt, output, 32, count of completed read transactions.

Function
REQ-008 SHALL implement the states IDLE, WR_DATA, WR_RESP, RD_FETCH and RD_DATA.
REQ-009 IDLE: awready=1; arready=1 only while awvalid=0, so a write wins when AW and AR are valid in the same cycle.
REQ-010 AW handshake: capture awid, awlen and line index awaddr[6+log2(DEPTH_LINES)-1:6], zero the beat counter, go to WR_DATA.
REQ-011 WR_DATA: wready=1; each wvalid beat writes only the bytes enabled by wstrb into the current line, then increments the line index modulo DEPTH_LINES.
REQ-012 WR_DATA SHALL go to WR_RESP on the beat where beat counter==awlen, regardless of wlast; a wlast arriving early is ignored.
REQ-013 WR_RESP: bvalid=1, bid=captured awid, bresp=OKAY (or per REQ-022); held stable until bready, then wr_cnt+1 and go to IDLE.
REQ-014 AR handshake: capture arid, arlen and line index, zero the beat counter, go to RD_FETCH.
REQ-015 RD_FETCH: one-cycle registered memory read of the current line, then go to RD_DATA.
REQ-016 RD_DATA: rvalid=1, rdata=fetched line, rid=captured arid, rresp=OKAY, rlast=(beat counter==arlen); all held stable until rready.
REQ-017 RD_DATA on rready: if rlast, rd_cnt+1 and go to IDLE; otherwise advance line index modulo DEPTH_LINES, beat counter+1, and go to RD_FETCH.
REQ-018 awsize/arsize SHALL be ignored; every beat is a full 64-byte line qualified by wstrb.
REQ-019 A read-after-write to the same line SHALL return the new data, since the write completes before B is issued.
REQ-020 wr_cnt and rd_cnt SHALL wrap from 0xFFFF_FFFF to 0.

Reset
REQ-021 Reset SHALL force IDLE and set awready=1, arready=1, and wready=0, bvalid=0, rvalid=0, wr_cnt=0, rd_cnt=0; reset mid-transaction abandons it without a response, and memory contents are not reset.

Configuration
REQ-022 SCRATCH_RANGE_CHK_EN defined: a burst whose start line plus len reaches or exceeds DEPTH_LINES (address bits above the index nonzero or overflow) drops all its writes, returns bresp=SLVERR, and reads return rdata=0 with rresp=SLVERR on every beat; beat count and handshakes are unchanged. Undefined: address bits above the index are ignored, indices wrap, and the response is always OKAY.

Structure
REQ-023 State enum, OKAY/SLVERR response constants and the line-byte width constant SHALL live in shared package cl_dram_dma_scratch_pkg.
REQ-024 Memory SHALL be a sub-module cl_dram_dma_scratch_ram (single port, byte-write-enable, 1-cycle registered read).

Verification
REQ-025 Single write: awaddr=0x40, awlen=0, wdata word0=0xDEADBEEF, wstrb=0xF -> bvalid with bresp=0, bid=awid, wr_cnt=1; readback of line 1 word0=0xDEADBEEF, other bytes unchanged.
REQ-026 4-beat burst: awaddr=0xFC0 (line 63), awlen=3 -> without the macro, lines 63,0,1,2 written; with the macro, bresp=SLVERR and no line modified.
REQ-027 Simultaneous AW (addr 0x80) and AR (addr 0x80) in the same cycle -> AW accepted first; the subsequent read returns the newly written data.
REQ-028 Read burst arlen=2 with rready low for 5 cycles on beat 1 -> rdata/rid/rlast stable during the stall, rlast only on beat 2, rd_cnt+1.
REQ-029 aresetn low during WR_DATA beat 2 of 4 -> next cycle bvalid=0, wready=0, awready=1; beats already written persist; a new write completes normally.
REQ-030 Write with awlen=1 and wlast on beat 0 -> two beats accepted, one B response.
